regfile_reader: RTL and testbench

REGFILE_READER -- requirements
Module: regfile_reader

---
 rtl/regfile_reader.sv | 107 ++++++++++
 tb/tb_regfile_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
// regfile_reader: DEPTH x WIDTH register file with a burst read port.
// A request (start address, length-1) is accepted in IDLE. Words are then
// streamed on a valid/ready response channel, one word per accepted beat,
// with the read address wrapping modulo DEPTH.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  register write port, usable in any state
//   req_valid/req_ready    burst request handshake
//   req_addr/req_len       burst start address and length minus one
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_last      response word and end-of-burst flag
//   busy                   burst in progress
module regfile_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [AW-1:0]    req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    r_remaining;
  logic [WIDTH-1:0] r_rsp_data;

  logic             w_accept;
  logic             w_beat;
  logic             w_load;
  logic [AW-1:0]    w_ptr_inc;
  logic [AW-1:0]    w_load_addr;
  logic [WIDTH-1:0] w_load_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = BURST;
      BURST:   if (rsp_ready && (r_remaining == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_beat    = (r_state == BURST) && rsp_ready;
  // A new word is loaded on acceptance or on any beat that is not the last
  assign w_load    = w_accept || (w_beat && (r_remaining != '0));
  assign w_ptr_inc = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
  assign w_load_addr = w_accept ? req_addr : w_ptr_inc;
  // Same-cycle write to the address being loaded is forwarded to the output
  assign w_load_data = (wr_en && (wr_addr == w_load_addr)) ? wr_data : r_mem[w_load_addr];

  // Register file storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Burst pointer, remaining count and output word; held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_rsp_data  <= '0;
    end else if (w_load) begin
      r_ptr       <= w_load_addr;
      r_remaining <= w_accept ? req_len : r_remaining - AW'(1);
      r_rsp_data  <= w_load_data;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == BURST);
  assign busy      = (r_state == BURST);
  assign rsp_last  = (r_state == BURST) && (r_remaining == '0);
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_regfile_reader.sv
// Self-checking bench for regfile_reader: directed scenarios followed by a
// random phase, all checked against a transaction-level model that keeps a
// list of pending burst addresses and the word currently on offer.
module tb_regfile_reader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [AW-1:0]    req_len;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_last;
  logic             busy;

  regfile_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents, pending addresses, current word
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_q[$];
  bit               m_busy;
  bit               m_last;
  logic [WIDTH-1:0] m_word;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    m_q.delete();
    m_busy = 0;
    m_last = 0;
    m_word = '0;
  endtask

  // Present the next pending address; its value is the register content
  // as of the edge on which it appears, then frozen until consumed.
  task automatic model_present();
    int a;
    a = m_q.pop_front();
    m_word = m_mem[a];
    m_last = (m_q.size() == 0);
  endtask

  task automatic check_model();
    chk("rsp_valid", WIDTH'(rsp_valid), WIDTH'(m_busy));
    chk("busy",      WIDTH'(busy),      WIDTH'(m_busy));
    chk("req_ready", WIDTH'(req_ready), WIDTH'(!m_busy));
    chk("rsp_last",  WIDTH'(rsp_last),  WIDTH'(m_busy && m_last));
    if (m_busy) chk("rsp_data", rsp_data, m_word);
  endtask

  // One clock: capture inputs, advance the model at the edge, check at negedge
  task automatic cyc();
    bit c_rst, c_we, c_rv, c_rr;
    logic [AW-1:0] c_wa, c_ra, c_rl;
    logic [WIDTH-1:0] c_wd;
    c_rst = rst; c_we = wr_en; c_wa = wr_addr; c_wd = wr_data;
    c_rv = req_valid; c_ra = req_addr; c_rl = req_len; c_rr = rsp_ready;
    @(posedge clk);
    if (c_rst) begin
      model_reset();
    end else begin
      if (c_we) m_mem[c_wa] = c_wd;
      if (m_busy) begin
        if (c_rr) begin
          if (m_q.size() == 0) begin
            m_busy = 0;
            m_last = 0;
          end else begin
            model_present();
          end
        end
      end else if (c_rv) begin
        for (int i = 0; i <= int'(c_rl); i++) m_q.push_back((int'(c_ra) + i) % int'(DEPTH));
        m_busy = 1;
        model_present();
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    req_valid = 0; req_addr = '0; req_len = '0; rsp_ready = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_req_ready", WIDTH'(req_ready), WIDTH'(1));
    chk("rst_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
    chk("rst_busy",      WIDTH'(busy),      WIDTH'(0));
    chk("rst_rsp_last",  WIDTH'(rsp_last),  WIDTH'(0));
    chk("rst_rsp_data",  rsp_data,          32'h0);
    cyc();
    cyc();
    rst = 0;

    // Reset then read: one zero word, last
    req_valid = 1; req_addr = 3'd3; req_len = 3'd0;
    cyc();
    chk("rd0_data", rsp_data, 32'h0);
    chk("rd0_last", WIDTH'(rsp_last), WIDTH'(1));
    req_valid = 0; rsp_ready = 1;
    cyc();
    chk("rd0_done", WIDTH'(busy), WIDTH'(0));

    // Fill registers with 0x100+k
    rsp_ready = 0;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1; wr_addr = AW'(k); wr_data = 32'h100 + k;
      cyc();
    end
    wr_en = 0;

    // Wrapping burst, no backpressure
    req_valid = 1; req_addr = 3'd6; req_len = 3'd3; rsp_ready = 1;
    cyc(); chk("wrap_b0", rsp_data, 32'h106); chk("wrap_l0", WIDTH'(rsp_last), WIDTH'(0));
    req_valid = 0;
    cyc(); chk("wrap_b1", rsp_data, 32'h107);
    cyc(); chk("wrap_b2", rsp_data, 32'h100);
    cyc(); chk("wrap_b3", rsp_data, 32'h101); chk("wrap_l3", WIDTH'(rsp_last), WIDTH'(1));
    cyc(); chk("wrap_idle", WIDTH'(rsp_valid), WIDTH'(0));

    // Backpressure on beat 2 with a write to the held register
    req_valid = 1;
    cyc(); chk("bp_b0", rsp_data, 32'h106);
    req_valid = 0;
    cyc(); chk("bp_b1", rsp_data, 32'h107);
    rsp_ready = 0; wr_en = 1; wr_addr = 3'd7; wr_data = 32'hDEAD;
    cyc(); chk("bp_hold0", rsp_data, 32'h107);
    wr_en = 0;
    cyc(); chk("bp_hold1", rsp_data, 32'h107);
    cyc(); chk("bp_hold2", rsp_data, 32'h107); chk("bp_hold_last", WIDTH'(rsp_last), WIDTH'(0));
    rsp_ready = 1;
    cyc(); chk("bp_b2", rsp_data, 32'h100);
    cyc(); chk("bp_b3", rsp_data, 32'h101); chk("bp_l3", WIDTH'(rsp_last), WIDTH'(1));
    cyc();

    // Bypass: write address 0 in the beat that loads it
    req_valid = 1; req_addr = 3'd6; req_len = 3'd3;
    cyc(); chk("byp_b0", rsp_data, 32'h106);
    req_valid = 0;
    cyc(); chk("byp_b1", rsp_data, 32'hDEAD);
    wr_en = 1; wr_addr = 3'd0; wr_data = 32'hBEEF;
    cyc(); chk("byp_b2", rsp_data, 32'hBEEF);
    wr_en = 0;
    cyc(); chk("byp_b3", rsp_data, 32'h101);
    cyc();

    // Requests while busy are ignored until the cycle after the last beat
    req_valid = 1; req_addr = 3'd4; req_len = 3'd2;
    cyc(); chk("ign_b0", rsp_data, 32'h104);
    req_addr = 3'd2; req_len = 3'd0;
    cyc(); chk("ign_b1", rsp_data, 32'h105);
    cyc(); chk("ign_b2", rsp_data, 32'h106); chk("ign_l2", WIDTH'(rsp_last), WIDTH'(1));
    cyc(); chk("ign_idle", WIDTH'(req_ready), WIDTH'(1));
    cyc(); chk("ign_served", rsp_data, 32'h102); chk("ign_busy", WIDTH'(busy), WIDTH'(1));
    req_valid = 0;
    cyc();

    // Reset mid-burst, write during reset dropped
    req_valid = 1; req_addr = 3'd0; req_len = 3'd7;
    cyc(); chk("mr_b0", rsp_data, 32'hBEEF);
    req_valid = 0;
    cyc(); chk("mr_b1", rsp_data, 32'h101);
    rst = 1; wr_en = 1; wr_addr = 3'd5; wr_data = 32'h5555;
    #1;
    chk("mr_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
    chk("mr_busy",      WIDTH'(busy),      WIDTH'(0));
    chk("mr_last",      WIDTH'(rsp_last),  WIDTH'(0));
    chk("mr_data",      rsp_data,          32'h0);
    model_reset();
    cyc();
    rst = 0; wr_en = 0;
    req_valid = 1; req_addr = 3'd0; req_len = 3'd7;
    for (int k = 0; k < 8; k++) begin
      cyc();
      req_valid = 0;
      chk("mr_zero", rsp_data, 32'h0);
    end
    cyc();

    // Random phase
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_addr   = AW'($urandom_range(0, 7));
      wr_data   = $urandom;
      req_valid = ($urandom_range(0, 1) == 0);
      req_addr  = AW'($urandom_range(0, 7));
      req_len   = AW'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    rst = 0;
    idle_inputs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
